ifconv_round: RTL

//  Rounding/pack stage directly downstream of the integer-to-float normaliser.

---
 rtl/ifconv_round_if.sv | 37 +++
 rtl/ifconv_round.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ifconv_round_if.sv
// Bus between the int-to-float normaliser and the rounding/pack stage.
// Carries the unrounded operand in and the packed, typed result out.
`ifndef PTYPE_SNGL
`define PTYPE_SNGL 2'd1
`endif
`ifndef PTYPE_DBL
`define PTYPE_DBL 2'd2
`endif
`ifndef PTYPE_EXT
`define PTYPE_EXT 2'd3
`endif

interface ifconv_round_if;
    logic        en;
    logic        sgn;
    logic [15:0] expn;
    logic [63:0] mant;
    logic        is_zero;
    logic        toSNG;
    logic        toDBL;
    logic        toEXT;
    logic [1:0]  rmode;
    logic [81:0] res;
    logic [1:0]  rtyp;
    logic        vld;
    logic        inexact;

    modport master (
        output en, sgn, expn, mant, is_zero, toSNG, toDBL, toEXT, rmode,
        input  res, rtyp, vld, inexact
    );

    modport slave (
        input  en, sgn, expn, mant, is_zero, toSNG, toDBL, toEXT, rmode,
        output res, rtyp, vld, inexact
    );
endinterface

// File: rtl/ifconv_round.sv
// Two-stage round-and-pack after the int-to-float normaliser: stage 1 decides
// the increment per target precision, stage 2 applies it and packs to 82 bits.
module ifconv_round (
    input logic           clk,
    input logic           rst,
    input logic           clkEn,
    ifconv_round_if.slave bus
);
    localparam int SNG_LSB = 40;
    localparam int DBL_LSB = 11;

    typedef enum logic [1:0] {TGT_SNG, TGT_DBL, TGT_EXT} tgt_e;

    // stage-1 next-state
    tgt_e        tgt_d;
    logic        lsb_b, grd, stk, inc_d, inx_d;
    logic [63:0] trunc_d;

    // stage-1 registers
    logic        s1_vld, s1_sgn, s1_zero, s1_inc, s1_inx;
    logic [15:0] s1_expn;
    logic [63:0] s1_mant;
    tgt_e        s1_tgt;

    // stage-2 combinational result
    logic [64:0] step, sum;
    logic [63:0] m_rnd;
    logic [15:0] e_rnd;
    logic [81:0] res_d;
    logic [1:0]  rtyp_d;

    // output registers
    logic        vld_q, inx_q;
    logic [81:0] res_q;
    logic [1:0]  rtyp_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        tgt_d   = TGT_EXT;
        lsb_b   = 1'b0;
        grd     = 1'b0;
        stk     = 1'b0;
        inc_d   = 1'b0;
        trunc_d = bus.mant;
        case ({bus.toSNG, bus.toDBL, bus.toEXT})
            3'b100:  tgt_d = TGT_SNG;
            3'b010:  tgt_d = TGT_DBL;
            default: tgt_d = TGT_EXT;
        endcase
        case (tgt_d)
            TGT_SNG: begin
                lsb_b   = bus.mant[SNG_LSB];
                grd     = bus.mant[SNG_LSB-1];
                stk     = |bus.mant[SNG_LSB-2:0];
                trunc_d = {bus.mant[63:SNG_LSB], {SNG_LSB{1'b0}}};
            end
            TGT_DBL: begin
                lsb_b   = bus.mant[DBL_LSB];
                grd     = bus.mant[DBL_LSB-1];
                stk     = |bus.mant[DBL_LSB-2:0];
                trunc_d = {bus.mant[63:DBL_LSB], {DBL_LSB{1'b0}}};
            end
            default: ;
        endcase
        case (bus.rmode)
            2'd0: inc_d = grd & (stk | lsb_b);
            2'd1: inc_d = 1'b0;
            2'd2: inc_d = bus.sgn & (grd | stk);
            2'd3: inc_d = ~bus.sgn & (grd | stk);
            default: inc_d = 1'b0;
        endcase
        inx_d = grd | stk;
        if (bus.is_zero) begin
            inc_d = 1'b0;
            inx_d = 1'b0;
        end
    end

    always_comb begin
        step = 65'd1;
        case (s1_tgt)
            TGT_SNG: step = 65'd1 << SNG_LSB;
            TGT_DBL: step = 65'd1 << DBL_LSB;
            default: step = 65'd1;
        endcase
        sum = {1'b0, s1_mant} + (s1_inc ? step : 65'd0);
        // Carry out of the mantissa renormalises to 1.0 at the next exponent.
        m_rnd = sum[64] ? 64'h8000_0000_0000_0000 : sum[63:0];
        e_rnd = sum[64] ? s1_expn + 16'd1 : s1_expn;
        res_d  = '0;
        rtyp_d = `PTYPE_EXT;
        case (s1_tgt)
            TGT_SNG: begin
                res_d  = {49'b0, e_rnd[15], s1_sgn, e_rnd[7:0], m_rnd[62:SNG_LSB]};
                rtyp_d = `PTYPE_SNGL;
            end
            TGT_DBL: begin
                res_d  = {16'b0, e_rnd[15], s1_sgn, e_rnd[10:0], m_rnd[62:43],
                          1'b0, m_rnd[42:DBL_LSB]};
                rtyp_d = `PTYPE_DBL;
            end
            default: begin
                res_d  = {s1_sgn, e_rnd[14:0], e_rnd[15], m_rnd[63:32], 1'b0, m_rnd[31:0]};
                rtyp_d = `PTYPE_EXT;
            end
        endcase
        if (s1_zero) res_d = '0;
    end

    // NOTE: the payload registers are reset along with the valids so the
    // outputs read as zero straight out of reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_sgn  <= 1'b0;
            s1_expn <= '0;
            s1_mant <= '0;
            s1_tgt  <= TGT_SNG;
            s1_zero <= 1'b0;
            s1_inc  <= 1'b0;
            s1_inx  <= 1'b0;
            vld_q   <= 1'b0;
            res_q   <= '0;
            rtyp_q  <= '0;
            inx_q   <= 1'b0;
        end else if (clkEn) begin
            // NOTE: non-blocking assignments so both stages sample pre-edge values.
            s1_vld <= bus.en;
            if (bus.en) begin
                s1_sgn  <= bus.sgn;
                s1_expn <= bus.expn;
                s1_mant <= trunc_d;
                s1_tgt  <= tgt_d;
                s1_zero <= bus.is_zero;
                s1_inc  <= inc_d;
                s1_inx  <= inx_d;
            end
            vld_q <= s1_vld;
            if (s1_vld) begin
                res_q  <= res_d;
                rtyp_q <= rtyp_d;
                inx_q  <= s1_inx;
            end
        end
    end

    assign bus.vld     = vld_q;
    assign bus.res     = res_q;
    assign bus.rtyp    = rtyp_q;
    assign bus.inexact = inx_q;
endmodule
